// File: rtl/hit_latency_buffer.sv
// hit_latency_buffer
//
// Holds time-stamped pixel hits in arrival (BCID) order until the trailing,
// latency-delayed BCID catches up with each hit's timestamp. When it does,
// the hit is released to readout if the trigger qualified that BCID, and
// discarded otherwise.
//
// Ports:
//   Clk        - single clock
//   Reset      - asynchronous, active-high reset
//   HitValid   - a hit is presented this cycle
//   HitData    - hit payload
//   BcidIn     - leading BCID, stamped onto the incoming hit
//   BcidTrail  - latency-delayed BCID from the slave counter
//   Trigger    - qualifies the BCID currently on BcidTrail
//   OutValid   - head entry is triggered and available
//   OutData    - head payload (0 while OutValid=0)
//   OutBcid    - head timestamp (0 while OutValid=0)
//   OutReady   - readout takes the head when OutValid & OutReady
//   Full       - buffer holds 2**DEPTH_LOG2 entries
//   Overflow   - sticky, a hit was lost since reset
//   DropCount  - saturating count of untriggered hits discarded
//   LostCount  - saturating count of hits lost to overflow
//
// Configuration macro: HIT_LATENCY_BUFFER_STATS_EN
//   defined   - DropCount/LostCount are saturating 16-bit registers
//   undefined - DropCount/LostCount are tied to 0

module hit_latency_buffer #(
    parameter int BCID_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  HitValid,
    input  logic [DATA_WIDTH-1:0] HitData,
    input  logic [BCID_WIDTH-1:0] BcidIn,
    input  logic [BCID_WIDTH-1:0] BcidTrail,
    input  logic                  Trigger,
    output logic                  OutValid,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic [BCID_WIDTH-1:0] OutBcid,
    input  logic                  OutReady,
    output logic                  Full,
    output logic                  Overflow,
    output logic [15:0]           DropCount,
    output logic [15:0]           LostCount
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        HEAD_WAIT,
        HEAD_ACCEPT,
        HEAD_DROP,
        HEAD_PRESENT
    } head_action_e;

    // Pointers carry one extra bit so that full and empty can be told apart.
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]      accepted_q, accepted_d;
    logic                  overflow_q, overflow_d;

    // Payload storage is not reset; only the control state is.
    logic [BCID_WIDTH-1:0] mem_bcid [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
    logic                  empty, full;
    logic [BCID_WIDTH-1:0] head_diff;
    logic                  head_past;
    head_action_e          head_action;
    logic                  do_drop, do_read, do_pop, do_push, hit_lost;
    logic [DEPTH-1:0]      wr_sel, acc_sel;

    assign wr_idx = wr_ptr_q[DEPTH_LOG2-1:0];
    assign rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);

    // Modular age of the head. An MSB of 1 means the head is still in the
    // future relative to the trailing BCID; a non-zero age with MSB 0 means
    // its BCID has already passed.
    assign head_diff = BcidTrail - mem_bcid[rd_idx];
    assign head_past = (head_diff != '0) && !head_diff[BCID_WIDTH-1];

    always_comb begin
        head_action = HEAD_WAIT;
        if (!empty) begin
            if (accepted_q[rd_idx]) begin
                head_action = HEAD_PRESENT;
            end else if ((head_diff == '0) && Trigger) begin
                head_action = HEAD_ACCEPT;
            end else if (head_past) begin
                head_action = HEAD_DROP;
            end
        end
    end

    assign do_drop  = (head_action == HEAD_DROP);
    assign do_read  = (head_action == HEAD_PRESENT) && OutReady;
    assign do_pop   = do_drop || do_read;
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign do_push  = HitValid && (!full || do_pop);
    assign hit_lost = HitValid && full && !do_pop;

    assign wr_sel  = do_push ? (DEPTH'(1) << wr_idx) : '0;
    assign acc_sel = (head_action == HEAD_ACCEPT) ? (DEPTH'(1) << rd_idx) : '0;

    // A pushed slot starts unaccepted; accept and push never hit the same
    // slot because a push into the head slot requires the head to pop.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_accepted
            assign accepted_d[gi] = acc_sel[gi] | (accepted_q[gi] & ~wr_sel[gi]);
        end
    endgenerate

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_push};
        rd_ptr_d   = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_pop};
        overflow_d = overflow_q | hit_lost;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            accepted_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            accepted_q <= accepted_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_bcid[wr_idx] <= BcidIn;
            mem_data[wr_idx] <= HitData;
        end
    end

    // Payload is gated by OutValid so the outputs read 0 during and after
    // reset even though the storage itself is not cleared.
    assign OutValid = (head_action == HEAD_PRESENT);
    assign OutData  = OutValid ? mem_data[rd_idx] : '0;
    assign OutBcid  = OutValid ? mem_bcid[rd_idx] : '0;
    assign Full     = full;
    assign Overflow = overflow_q;

`ifdef HIT_LATENCY_BUFFER_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] lost_cnt_q, lost_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        lost_cnt_d = lost_cnt_q;
        if (do_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (hit_lost && (lost_cnt_q != 16'hFFFF)) begin
            lost_cnt_d = lost_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            drop_cnt_q <= '0;
            lost_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign DropCount = drop_cnt_q;
    assign LostCount = lost_cnt_q;
`else
    assign DropCount = 16'd0;
    assign LostCount = 16'd0;
`endif

endmodule

// File: doc/hit_latency_buffer.md
# hit_latency_buffer

Holds time-stamped hits in BCID order until the trailing BCID from the slave-mode BCID counter reaches each hit's timestamp. At that point the hit is either released to readout, if the trigger qualifies that BCID, or discarded. This block is the consumer of the latency-delayed BCID. It sits between the pixel hit front-end, which stamps hits with the leading BCID, and the readout serializer.

## Interface
Parameters:
- BCID_WIDTH, 9, width of all BCID values
- DATA_WIDTH, 8, hit payload width
- DEPTH_LOG2, 3, buffer holds 2**DEPTH_LOG2 entries

Ports:
- Clk  input  1  single clock
- Reset  input  1  asynchronous, active-high reset
- HitValid  input  1  a hit is presented this cycle
- HitData  input  DATA_WIDTH  hit payload
- BcidIn  input  BCID_WIDTH  leading BCID; stamped onto the incoming hit
- BcidTrail  input  BCID_WIDTH  latency-delayed BCID from the slave counter
- Trigger  input  1  qualifies the BCID currently on BcidTrail
- OutValid  output  1  head entry is triggered and available
- OutData  output  DATA_WIDTH  head payload
- OutBcid  output  BCID_WIDTH  head timestamp
- OutReady  input  1  readout accepts the head when OutValid & OutReady
- Full  output  1  buffer holds 2**DEPTH_LOG2 entries
- Overflow  output  1  sticky; a hit was lost since reset
- DropCount  output  16  untriggered hits discarded (stats build only)
- LostCount  output  16  hits lost to overflow (stats build only)

## Operation
- Buffer is a circular FIFO of {bcid, data, accepted} entries. Read/write pointers are DEPTH_LOG2+1 bits wide; the MSB distinguishes full from empty.
- Push: on HitValid, store {BcidIn, HitData, accepted=0}. Hits arrive in non-decreasing BCID order modulo 2**BCID_WIDTH, so only the head is examined.
- Head age: diff = (BcidTrail - head.bcid) mod 2**BCID_WIDTH.
- Head state machine, evaluated each cycle when not empty:
  - WAIT: diff == 0 and Trigger=0, or diff >= 2**(BCID_WIDTH-1), meaning the head is in the future. Hold.
  - ACCEPT: diff == 0, Trigger=1, accepted=0. Set accepted at the clock edge.
  - DROP: accepted=0 and 1 <= diff < 2**(BCID_WIDTH-1). Pop; DropCount += 1.
  - PRESENT: accepted=1. OutValid=1. Pop on OutReady. Once accepted, the entry is never dropped, regardless of later BcidTrail motion.
- Because BcidTrail can hold for several cycles under the prescaler, Trigger may be asserted on any cycle while diff == 0.
- Full with push and no pop in the same cycle: the hit is discarded, Overflow is set, LostCount += 1.
- Full with push and pop in the same cycle: the push is accepted.
- Empty with push: the entry becomes head at the next cycle. There is no same-cycle bypass.
- Counters saturate at 0xFFFF.
- Reset, asynchronous and usable mid-operation: pointers, all accepted flags, Overflow and both counters clear immediately. Any buffered hits are lost.

## Timing
- Reset values: OutValid=0, OutData=0, OutBcid=0, Full=0, Overflow=0, DropCount=0, LostCount=0.
- OutData and OutBcid are driven from the head storage registers; they are don't-care when OutValid=0 but must be stable while OutValid=1.
- Latency:
  - Hit pushed at edge N is head-eligible from cycle N+1.
  - Trigger sampled at edge M gives OutValid=1 in cycle M+1.
  - OutValid & OutReady at edge K pops the entry. The next head is visible in cycle K+1.
- Throughput: one pop per cycle, by DROP or by readout. A new head needs at least one cycle before ACCEPT.
- Wrap-around: diff uses modular subtraction. Head bcid 0x1FF with BcidTrail 0x000 gives diff=1, so the head is dropped if not accepted.

## Configuration
- HIT_LATENCY_BUFFER_STATS_EN defined: DropCount and LostCount are implemented as saturating 16-bit registers.
- Not defined: both outputs are tied to 0 and no counter logic is synthesized. Overflow is always present.

## Test plan
- Trigger match: hit 0xA5 at BcidIn=0x010; hold BcidTrail=0x010 with Trigger=1 for 1 cycle -> OutValid=1, OutData=0xA5, OutBcid=0x010 the next cycle; popped on OutReady.
- No trigger: hit at 0x020; BcidTrail steps 0x020 -> 0x021 with Trigger=0 -> no OutValid; DropCount=1 (stats build).
- Backpressure past window: accepted hit with OutReady=0 while BcidTrail advances 5 BCIDs -> entry still presented; taken intact when OutReady=1.
- Overflow: 9 hits at DEPTH_LOG2=3, no pops -> Full=1 after the 8th hit, Overflow=1, LostCount=1. Push together with a pop while full -> no loss.
- Wrap: hits at 0x1FF and 0x000, Trigger only at BcidTrail=0x000 -> 0x1FF dropped, 0x000 output.
- Async reset with 4 entries buffered and OutValid=1 -> all outputs 0 immediately, without a clock edge; buffer empty afterwards.
